// File: rtl/regs_write_arbiter.sv
// Write-port arbiter for the picoMIPS register file: ALU writeback (A) has priority,
// and the I/O/debug path (B) is queued in a small FIFO with starvation protection.
module regs_write_arbiter #(
    parameter int n          = 8,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [2:0]   a_rd,
    input  logic [n-1:0] a_data,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic [2:0]   b_rd,
    input  logic [n-1:0] b_data,
    output logic         w,
    output logic [2:0]   wr_rd,
    output logic [n-1:0] wr_data,
    output logic [7:0]   pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic         f_live [DEPTH];
    logic [2:0]   f_rd   [DEPTH];
    logic [n-1:0] f_data [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [SW-1:0] starve;

    logic empty, head_live, head_dead, force_b;
    logic issue_a, issue_b, pop, enq;

    always_comb begin
        empty     = (count == '0);
        head_live = !empty && f_live[head];
        head_dead = !empty && !f_live[head];
        force_b   = head_live && (starve == SW'(STARVE_MAX));
        issue_b   = head_live && (force_b || !a_valid);
        pop       = head_dead || issue_b;
        issue_a   = !issue_b && a_valid && !force_b;
        enq       = b_valid && b_ready;
    end

    assign a_ready = !force_b;
    assign b_ready = (count < CW'(DEPTH));

    // Popped entries have live cleared, so pending can scan every slot.
    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (f_live[AW'(i)]) pending[f_rd[AW'(i)]] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                f_live[AW'(i)] <= 1'b0;
                f_rd[AW'(i)]   <= '0;
                f_data[AW'(i)] <= '0;
            end
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            starve  <= '0;
            w       <= 1'b0;
            wr_rd   <= '0;
            wr_data <= '0;
        end else begin
            // Kill, then pop, then enqueue: a same-cycle B entry is newer than A.
            if (issue_a && a_rd != 3'd0) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (f_rd[AW'(i)] == a_rd) f_live[AW'(i)] <= 1'b0;
                end
            end
            if (pop) begin
                f_live[head] <= 1'b0;
                head         <= head + 1'b1;
            end
            if (enq) begin
                f_live[tail] <= 1'b1;
                f_rd[tail]   <= b_rd;
                f_data[tail] <= b_data;
                tail         <= tail + 1'b1;
            end
            if (enq && !pop)
                count <= count + 1'b1;
            else if (!enq && pop)
                count <= count - 1'b1;

            if (empty || pop)
                starve <= '0;
            else if (head_live && starve != SW'(STARVE_MAX))
                starve <= starve + 1'b1;

            w <= 1'b0;
            if (issue_b && f_rd[head] != 3'd0) begin
                w       <= 1'b1;
                wr_rd   <= f_rd[head];
                wr_data <= f_data[head];
            end else if (issue_a && a_rd != 3'd0) begin
                w       <= 1'b1;
                wr_rd   <= a_rd;
                wr_data <= a_data;
            end
        end
    end

endmodule
